fixed_point_divider: RTL and testbench

//  Sequential signed fixed-point divider: quotient = (dividend << FRAC) / divisor.
//  It is the inverse companion of the shift-add multiplier in the FC datapath.
//  It serves the normalisation and averaging stages that divide activations by

---
 rtl/fixed_point_divider_pkg.sv | 18 +
 rtl/fixed_point_saturate.sv | 35 +++
 rtl/fixed_point_divider.sv | 128 ++++++++++++
 tb/tb_fixed_point_divider.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_divider_pkg.sv
// Shared definitions for the fixed-point divider slice.
// Default widths, FSM encoding and Q-format limit constants.
package fixed_point_divider_pkg;

  localparam int N_DEF    = 16;
  localparam int FRAC_DEF = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [N_DEF-1:0] FP_MAX = 16'h7FFF;
  localparam logic [N_DEF-1:0] FP_MIN = 16'h8000;

endpackage

// File: rtl/fixed_point_saturate.sv
// Applies a sign to an unsigned wide magnitude and clamps
// the result into a signed N-bit word, flagging saturation.
module fixed_point_saturate
  import fixed_point_divider_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = N_DEF + FRAC_DEF
) (
  input  logic [W-1:0] mag,
  input  logic         sign,
  output logic [N-1:0] value,
  output logic         overflow
);

  localparam logic [N-1:0] MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN = {1'b1, {(N-1){1'b0}}};
  localparam logic [W-1:0] POS_LIM = W'(MAX);
  localparam logic [W-1:0] NEG_LIM = W'(MIN);

  // A negative result may reach one step further than a positive one.
  always_comb begin
    value    = mag[N-1:0];
    overflow = 1'b0;
    if (!sign && mag > POS_LIM) begin
      value    = MAX;
      overflow = 1'b1;
    end else if (sign && mag > NEG_LIM) begin
      value    = MIN;
      overflow = 1'b1;
    end else if (sign) begin
      value = -mag[N-1:0];
    end
  end

endmodule

// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider, one quotient bit per clock.
// Restoring division on magnitudes, then sign fix and saturation.
module fixed_point_divider
  import fixed_point_divider_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         finish,
  output logic [N-1:0] quotient,
  output logic         overflow,
  output logic         div_by_zero
);

  localparam int W  = N + FRAC;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [N-1:0] MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN = {1'b1, {(N-1){1'b0}}};

  state_t state;
  state_t state_nx;

  logic [W-1:0]  work;
  logic [N-1:0]  rem;
  logic [N-1:0]  b_mag;
  logic          sign;
  logic [CW-1:0] count;

  logic [N-1:0]  a_abs;
  logic [N-1:0]  b_abs;
  logic [N:0]    rem_sh;
  logic [N-1:0]  rem_tr;
  logic          q_bit;
  logic          accept;
  logic          zero_div;
  logic [N-1:0]  sat_val;
  logic          sat_ovf;

  assign a_abs    = dividend[N-1] ? -dividend : dividend;
  assign b_abs    = divisor[N-1] ? -divisor : divisor;
  assign zero_div = (divisor == '0);
  assign accept   = start && (state == IDLE || state == DONE);

  // The stored remainder is always below b, so it fits in N bits.
  assign rem_sh = {rem, work[W-1]};
  assign q_bit  = (rem_sh >= {1'b0, b_mag});
  assign rem_tr = rem_sh[N-1:0] - b_mag;

  fixed_point_saturate #(
    .N(N),
    .W(W)
  ) u_sat (
    .mag      (work),
    .sign     (sign),
    .value    (sat_val),
    .overflow (sat_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else if (enable) begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) state_nx = zero_div ? FIX : CALC;
      end
      CALC: begin
        if (count == LAST) state_nx = FIX;
      end
      FIX: state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == CALC) || (state == FIX);
    finish = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      work        <= '0;
      rem         <= '0;
      b_mag       <= '0;
      sign        <= 1'b0;
      count       <= '0;
      quotient    <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (enable) begin
      if (accept) begin
        sign        <= dividend[N-1] ^ divisor[N-1];
        b_mag       <= b_abs;
        work        <= {a_abs, {FRAC{1'b0}}};
        rem         <= '0;
        count       <= '0;
        overflow    <= 1'b0;
        div_by_zero <= zero_div;
      end else if (state == CALC) begin
        rem   <= q_bit ? rem_tr : rem_sh[N-1:0];
        work  <= {work[W-2:0], q_bit};
        count <= (count == LAST) ? '0 : count + 1'b1;
      end else if (state == FIX) begin
        if (div_by_zero) begin
          quotient <= sign ? MIN : MAX;
        end else begin
          quotient <= sat_val;
          overflow <= sat_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_fixed_point_divider.sv
// Directed scoreboard bench for the fixed-point divider.
// Expected results come from an integer reference model.
module tb_fixed_point_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        finish;
  logic [15:0] quotient;
  logic        overflow;
  logic        div_by_zero;

  typedef struct {
    logic [15:0] q;
    logic        ovf;
    logic        dbz;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fixed_point_divider dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .finish      (finish),
    .quotient    (quotient),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  function automatic exp_t model(logic [15:0] dd, logic [15:0] dv);
    exp_t   e;
    longint a;
    longint b;
    longint q;
    logic   s;
    s = dd[15] ^ dv[15];
    a = dd[15] ? 65536 - longint'(dd) : longint'(dd);
    b = dv[15] ? 65536 - longint'(dv) : longint'(dv);
    e.ovf = 1'b0;
    e.dbz = 1'b0;
    if (b == 0) begin
      e.dbz = 1'b1;
      e.q   = s ? 16'h8000 : 16'h7FFF;
    end else begin
      q = (a * 1024) / b;
      if (!s && q > 32767) begin
        e.q   = 16'h7FFF;
        e.ovf = 1'b1;
      end else if (s && q > 32768) begin
        e.q   = 16'h8000;
        e.ovf = 1'b1;
      end else begin
        e.q = s ? 16'(-q) : 16'(q);
      end
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(string tag, int lat, int n0);
    int   n;
    exp_t e;
    n = n0;
    while (!finish && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 16'(n), 16'(lat));
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 16'd1, 16'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_q"}, quotient, e.q);
      chk({tag, "_ovf"}, {15'd0, overflow}, {15'd0, e.ovf});
      chk({tag, "_dbz"}, {15'd0, div_by_zero}, {15'd0, e.dbz});
    end
  endtask

  task automatic launch(logic [15:0] dd, logic [15:0] dv);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    sb.push_back(model(dd, dv));
    tick();
    start = 1'b0;
    chk("busy_after_start", {15'd0, busy}, 16'd1);
  endtask

  task automatic run_op(string tag, logic [15:0] dd, logic [15:0] dv,
                        int lat);
    launch(dd, dv);
    wait_done(tag, lat, 1);
  endtask

  initial begin
    logic [15:0] held;
    reset    = 1'b1;
    enable   = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    reset = 1'b0;
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_finish", {15'd0, finish}, 16'd0);
    chk("rst_q", quotient, 16'h0000);
    chk("rst_ovf", {15'd0, overflow}, 16'd0);
    chk("rst_dbz", {15'd0, div_by_zero}, 16'd0);

    run_op("p3_div_1p5", 16'h0C00, 16'h0600, 28);
    chk("p3_div_1p5_const", quotient, 16'h0800);
    run_op("n3_div_1p5", 16'hF400, 16'h0600, 28);
    run_op("trunc", 16'h0400, 16'h0C00, 28);
    chk("trunc_const", quotient, 16'h0155);
    run_op("sat_pos", 16'h7C00, 16'h0040, 28);
    run_op("min_div_neg1", 16'h8000, 16'hFC00, 28);
    run_op("neg_div_pos_neg", 16'hF000, 16'hF800, 28);
    run_op("dbz", 16'hFC00, 16'h0000, 2);
    chk("dbz_ovf_const", {15'd0, overflow}, 16'd0);
    run_op("zero_dividend", 16'h0000, 16'hF000, 28);

    held = quotient;
    tick();
    tick();
    chk("done_hold_q", quotient, held);
    chk("done_hold_fin", {15'd0, finish}, 16'd1);

    dividend = 16'h1400;
    divisor  = 16'h0300;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {15'd0, busy}, 16'd0);
    chk("abort_finish", {15'd0, finish}, 16'd0);
    chk("abort_q", quotient, 16'h0000);
    run_op("after_abort", 16'h1400, 16'h0300, 28);

    launch(16'hE800, 16'h0500);
    for (int i = 0; i < 4; i++) tick();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("stall_busy", {15'd0, busy}, 16'd1);
    enable   = 1'b1;
    dividend = 16'h0100;
    divisor  = 16'h0100;
    start    = 1'b1;
    tick();
    start = 1'b0;
    wait_done("stall", 33, 11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
